// File: rtl/charlie_pwm_scanner.sv
// charlie_pwm_scanner: double-buffered charlieplex PWM scanner with dead-time blanking between LEDs.
// Optional macro CHARLIE_SKIP_DARK_EN: dark LEDs take a single cycle instead of a full slot.
module charlie_pwm_scanner #(
    parameter int PINS        = 8,
    parameter int NUM_LEDS    = 56,
    parameter int PWM_BITS    = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_LEDS*PWM_BITS-1:0] frame_in,
    input  logic                         frame_load,
    output logic [PINS-1:0]              pin_out,
    output logic [PINS-1:0]              pin_oe,
    output logic                         frame_done,
    output logic                         busy
);
`ifdef CHARLIE_SKIP_DARK_EN
    localparam bit SKIP_DARK = 1'b1;
`else
    localparam bit SKIP_DARK = 1'b0;
`endif
    localparam int LW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
    localparam int CW = DW > PWM_BITS ? DW : PWM_BITS;
    localparam int FW = NUM_LEDS * PWM_BITS;
    localparam logic [CW-1:0] ON_LAST   = CW'(2**PWM_BITS - 2);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [LW-1:0] LED_LAST  = LW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, DEAD, ON} state_t;

    state_t              state, state_n;
    logic [LW-1:0]       led_idx, led_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [FW-1:0]       active, pending;
    logic                pending_valid, swap, slot_end, lit;
    logic [PWM_BITS-1:0] bright;
    int                  a, r, c;

    assign bright   = active[int'(led_idx)*PWM_BITS +: PWM_BITS];
    assign slot_end = (state == ON && cnt == ON_LAST) || (SKIP_DARK && state == DEAD && bright == '0);
    assign busy     = state != IDLE;

    always_comb begin
        state_n    = state;
        led_n      = led_idx;
        cnt_n      = cnt;
        swap       = 1'b0;
        frame_done = enable && slot_end && led_idx == LED_LAST;
        if (state == IDLE) begin
            if (enable) begin
                state_n = DEAD;
                led_n   = '0;
                cnt_n   = '0;
                swap    = 1'b1;
            end
        end else if (!enable) begin
            state_n = IDLE;
            led_n   = '0;
            cnt_n   = '0;
        end else if (slot_end) begin
            state_n = DEAD;
            cnt_n   = '0;
            led_n   = led_idx == LED_LAST ? '0 : led_idx + LW'(1);
            swap    = led_idx == LED_LAST;
        end else if (state == DEAD && cnt == DEAD_LAST) begin
            state_n = ON;
            cnt_n   = '0;
        end else begin
            cnt_n = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            led_idx       <= '0;
            cnt           <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            state   <= state_n;
            led_idx <= led_n;
            cnt     <= cnt_n;
            if (frame_load)
                pending <= frame_in;
            // a load coinciding with a swap bypasses pending so the newest frame wins
            if (swap && frame_load)
                active <= frame_in;
            else if (swap && pending_valid)
                active <= pending;
            pending_valid <= swap ? 1'b0 : (frame_load | pending_valid);
        end
    end

    always_comb begin
        a       = int'(led_idx) / (PINS - 1);
        r       = int'(led_idx) % (PINS - 1);
        c       = r < a ? r : r + 1;
        lit     = state == ON && cnt < CW'(bright);
        pin_oe  = lit ? (PINS'(1) << a) | (PINS'(1) << c) : '0;
        pin_out = lit ? PINS'(1) << a : '0;
    end
endmodule

// File: tb/tb_charlie_pwm_scanner.sv
// tb_charlie_pwm_scanner: randomized and directed checks against a frame-time reference model.
module tb_charlie_pwm_scanner;
    localparam int P = 3, N = 6, PB = 2, DC = 1;
    localparam int SLOT = DC + 2**PB - 1;
`ifdef CHARLIE_SKIP_DARK_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 0, rst = 1, enable = 0, frame_load = 0;
    logic [N*PB-1:0] frame_in = '0;
    logic [P-1:0]  pin_out, pin_oe;
    logic          frame_done, busy;

    charlie_pwm_scanner #(.PINS(P), .NUM_LEDS(N), .PWM_BITS(PB), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_in(frame_in), .frame_load(frame_load),
        .pin_out(pin_out), .pin_oe(pin_oe), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_act[N], m_pend[N];
    bit m_pv = 0, m_scan = 0, cmp_on = 0;
    int m_t = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fi(input int k);
        return int'(frame_in[k*PB +: PB]);
    endfunction

    function automatic int led_len(input int b);
        return (SKIP && b == 0) ? 1 : SLOT;
    endfunction

    function automatic int flen();
        int s = 0;
        for (int k = 0; k < N; k++) s += led_len(m_act[k]);
        return s;
    endfunction

    // reference: position within the frame plus the two buffers
    always @(posedge clk) begin
        bit sw;
        sw = 0;
        if (rst) begin
            m_scan = 0; m_t = 0; m_pv = 0; cmp_on = 1;
            for (int k = 0; k < N; k++) begin m_act[k] = 0; m_pend[k] = 0; end
        end else begin
            if (!m_scan) begin
                if (enable) begin m_scan = 1; m_t = 0; sw = 1; end
            end else if (!enable) begin
                m_scan = 0; m_t = 0;
            end else if (m_t == flen() - 1) begin
                m_t = 0; sw = 1;
            end else m_t++;
            if (sw && (frame_load || m_pv)) begin
                for (int k = 0; k < N; k++) m_act[k] = frame_load ? fi(k) : m_pend[k];
                m_pv = 0;
            end else if (frame_load) begin
                for (int k = 0; k < N; k++) m_pend[k] = fi(k);
                m_pv = 1;
            end
        end
    end

    always @(negedge clk) begin
        int base, led, off, a, r, c, e_oe, e_out, e_fd;
        if (cmp_on) begin
            e_oe = 0; e_out = 0; e_fd = 0; led = -1; off = 0; base = 0;
            if (m_scan) begin
                for (int k = 0; k < N; k++) begin
                    if (led < 0 && m_t < base + led_len(m_act[k])) begin led = k; off = m_t - base; end
                    base += led_len(m_act[k]);
                end
                if (led >= 0 && led_len(m_act[led]) == SLOT && off >= DC && off - DC < m_act[led]) begin
                    a = led / (P - 1); r = led % (P - 1); c = r < a ? r : r + 1;
                    e_oe = (1 << a) | (1 << c);
                    e_out = 1 << a;
                end
                e_fd = (enable && m_t == base - 1) ? 1 : 0;
            end
            chk("pin_oe", int'(pin_oe), e_oe);
            chk("pin_out", int'(pin_out), e_out);
            chk("frame_done", int'(frame_done), e_fd);
            chk("busy", int'(busy), int'(m_scan));
        end
    end

    task automatic wait_fd(input int lim, output int n);
        n = 0;
        while (!frame_done && n < lim) begin step(); n++; end
        if (n >= lim) chk("frame_done_timeout", n, -1);
    endtask

    task automatic load(input logic [N*PB-1:0] f);
        frame_in = f; frame_load = 1; step(); frame_load = 0;
    endtask

    int n, lit_cnt, fd_cnt;
    int exp_oe[N]  = '{3, 5, 3, 6, 5, 6};
    int exp_out[N] = '{1, 1, 2, 2, 4, 4};

    initial begin
        // reset with a simultaneous load that must be discarded
        frame_load = 1; frame_in = '1;
        step(); frame_load = 0; step(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_oe", int'(pin_oe), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_fd", int'(frame_done), 0);
        end
        enable = 1; lit_cnt = 0;
        for (int i = 0; i < 24; i++) begin step(); if (pin_oe != 0) lit_cnt++; end
        chk("rst_beats_load", lit_cnt, 0);
        enable = 0; step();

        // mapping: all LEDs at full brightness
        load('1);
        enable = 1; step();
        for (int t = 0; t < N * SLOT; t++) begin
            chk("map_oe", int'(pin_oe), (t % SLOT == 0) ? 0 : exp_oe[t / SLOT]);
            chk("map_out", int'(pin_out), (t % SLOT == 0) ? 0 : exp_out[t / SLOT]);
            if (t == N * SLOT - 1) chk("map_fd", int'(frame_done), 1);
            step();
        end
        enable = 0; step();

        // PWM: LED2 at brightness 1
        load(12'h010);
        enable = 1; step(); lit_cnt = 0;
        for (int t = 0; t < 24; t++) begin
            if (pin_oe != 0) begin
                lit_cnt++;
                chk("pwm_oe", int'(pin_oe), 3);
                chk("pwm_out", int'(pin_out), 2);
            end
            step();
        end
        chk("pwm_lit_cycles", lit_cnt, 1);
        enable = 0; step();

        // double buffer: A, mid-frame B, then C on the frame_done cycle
        load(12'h555);
        enable = 1; repeat (10) step();
        load(12'hFFF);
        wait_fd(200, n); step();
        wait_fd(200, n);
        frame_in = 12'h0C0; frame_load = 1; step(); frame_load = 0;
        repeat (SKIP ? 4 : 13) step();
        chk("dbuf_c_oe", int'(pin_oe), 6);
        chk("dbuf_c_out", int'(pin_out), 2);
        repeat (60) step();

        // abort mid-frame and restart from LED 0 with retained frame
        enable = 0; step(); load('1);
        enable = 1; step(); repeat (10) step();
        enable = 0; step();
        chk("abort_busy", int'(busy), 0);
        chk("abort_oe", int'(pin_oe), 0);
        fd_cnt = 0;
        for (int i = 0; i < 30; i++) begin if (frame_done) fd_cnt++; step(); end
        chk("abort_no_fd", fd_cnt, 0);
        enable = 1; step(); step();
        chk("restart_oe", int'(pin_oe), 3);
        chk("restart_out", int'(pin_out), 1);

        // frame period with only LED5 lit
        enable = 0; step(); load(12'hC00);
        enable = 1; step();
        wait_fd(200, n); step();
        wait_fd(200, n);
        chk("frame_period", n + 1, SKIP ? 9 : 24);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 79) == 0) enable = !enable;
            frame_load = $urandom_range(0, 24) == 0;
            frame_in = 12'($urandom);
            rst = $urandom_range(0, 999) == 0;
            step();
        end
        rst = 0; frame_load = 0; step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
